mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, multi-cycle memory between the fetch port (IF stage) and the
//  data port (MEM stage) of the 5-stage pipeline. Each port has a req/ready handshake.
//  Data requests win by default; a starvation counter guarantees fetch progress.
//  The pipeline uses (i_req & ~i_ready) for stallF and (d_req & ~d_ready) for the MEM stall.
// PARAMETERS
//  AW        32  address width (byte address)
//  DW        32  data width
//  MAX_WAIT  4   cycles a fetch may be denied in IDLE before it beats a data request (>=1)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset asserted)
//  i_req      in   1   fetch request, held with stable i_addr until i_ready
//  i_addr     in   AW  fetch address
//  i_ready    out  1   one-cycle pulse: fetch done, i_rdata valid this cycle
//  i_rdata    out  DW  fetch data (= mem_rdata)
//  d_req      in   1   data request, held with stable d_we/d_addr/d_wdata until d_ready
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_ready    out  1   one-cycle pulse: load/store done, d_rdata valid this cycle (loads)
//  d_rdata    out  DW  load data (= mem_rdata)
//  mem_req    out  1   memory request, held until mem_gnt
//  mem_we     out  1   memory write enable, qualified by mem_req
//  mem_addr   out  AW  memory address, registered
//  mem_wdata  out  DW  memory write data, registered
//  mem_gnt    in   1   memory accepts the request this cycle
//  mem_rvalid in   1   response (read data or write ack), one per accepted request
//  mem_rdata  in   DW  read data, valid with mem_rvalid
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0. mem_req, mem_we, mem_addr, mem_wdata, i_ready, d_ready = 0.
//  FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D. Only one request is outstanding at a time.
//  IDLE grant (registered):
//   - d_req & (~i_req | wait_cnt<MAX_WAIT) -> REQ_D.
//   - else if i_req -> REQ_I.
//   - at grant, capture addr/we/wdata into mem_* (mem_we=0 for fetch); mem_req=1 next cycle.
//  wait_cnt:
//   - +1 (saturating at MAX_WAIT) each IDLE cycle with i_req high and D granted.
//   - cleared when I is granted or when i_req is low.
//  REQ_x:
//   - mem_gnt=1 -> WAIT_x, mem_req=0 next cycle.
//   - x_req dropped before gnt (flush) -> IDLE, mem_req=0 next cycle; no ready pulse.
//  WAIT_x:
//   - x_ready = mem_rvalid (combinational); x_rdata = mem_rdata.
//   - on mem_rvalid -> IDLE.
//   - the pulse is issued even if x_req has dropped; the requester discards it.
//  mem_rvalid outside WAIT_x is ignored; no ready pulse.
//  Latency: req in IDLE at cycle 0, mem_gnt tied 1, rvalid at the first WAIT cycle
//   -> ready at cycle 2. Next grant no earlier than cycle 3 (one IDLE bubble per access).
//  Simultaneous i_req & d_req with wait_cnt<MAX_WAIT: D first, then I.
//  With wait_cnt==MAX_WAIT: I first.
//  i_ready and d_ready are never high in the same cycle.
//  Reset asserted mid-operation: immediate return to reset values.
//   A memory response arriving after reset release lands in IDLE and is ignored.
// TESTING
//  1 Fetch only: i_req, i_addr=0x40, mem_gnt=1, rvalid 1 cycle after gnt, rdata=0x8C0A0004
//    -> mem_addr=0x40, mem_we=0; i_ready pulse at cycle 2 with i_rdata=0x8C0A0004.
//  2 Store only: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_gnt delayed 3 cycles
//    -> mem_req held 3 cycles with stable addr/data; one d_ready pulse; no i_ready.
//  3 Conflict: i_req & d_req at cycle 0, both held -> D serviced first; i_ready only after
//    d_ready; no cycle with both ready pulses.
//  4 Starvation: i_req held, back-to-back d_req, MAX_WAIT=4 -> after 4 denied IDLE cycles
//    the fetch is granted ahead of the pending d_req; wait_cnt returns to 0.
//  5 Flush: i_req drops while in REQ_I with mem_gnt=0 -> mem_req falls next cycle,
//    no i_ready; a following d_req is serviced normally.
//  6 Reset in WAIT_D -> all outputs 0 immediately; a late mem_rvalid produces no d_ready;
//    the next fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, multi-cycle memory between the
// fetch port and the data port. Data wins by default; a saturating counter of
// denied fetch cycles lets a starved fetch beat a pending data request.
// Only one memory request is outstanding at a time.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nxt;
    logic          grant_d;
    logic          grant_i;

    // Next-state, grant decision and starvation counter update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        grant_d      = 1'b0;
        grant_i      = 1'b0;

        unique case (state)
            IDLE: begin
                if (d_req && (!i_req || wait_cnt < WAIT_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = REQ_D;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = REQ_I;
                end
            end
            // A granted memory wins over a same-cycle drop: the access is already accepted.
            REQ_I: begin
                if (mem_gnt)     state_nxt = WAIT_I;
                else if (!i_req) state_nxt = IDLE;
            end
            REQ_D: begin
                if (mem_gnt)     state_nxt = WAIT_D;
                else if (!d_req) state_nxt = IDLE;
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Count fetch denials while the fetch keeps asking; forget them once it is served or gone.
        if (!i_req || grant_i) begin
            wait_cnt_nxt = '0;
        end else if (grant_d && wait_cnt < WAIT_MAX) begin
            wait_cnt_nxt = wait_cnt + CW'(1);
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Registered memory request; address/data captured at grant and held until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_nxt == REQ_I) || (state_nxt == REQ_D);
            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
            end
        end
    end

    // Ready pulses follow the memory response only in the matching wait state.
    assign i_ready = (state == WAIT_I) && mem_rvalid;
    assign d_ready = (state == WAIT_D) && mem_rvalid;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the arbiter kept in the bench.
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    localparam int NONE = 0;
    localparam int PI   = 1;
    localparam int PD   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    // model: who owns the memory, whether the memory accepted it, and the fetch denial count
    int            m_owner;
    bit            m_acc;
    int            m_starve;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;

    bit obs_i;
    bit obs_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = NONE;
        m_acc    = 1'b0;
        m_starve = 0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
    endtask

    // One clock edge of the arbiter rules, applied to the inputs held during the ending cycle.
    task automatic model_step();
        bit dwin;
        if (!reset) begin
            model_reset();
        end else if (m_owner == NONE) begin
            dwin = d_req && (!i_req || m_starve < MAX_WAIT);
            if (dwin) begin
                m_owner  = PD;
                m_acc    = 1'b0;
                m_addr   = d_addr;
                m_we     = d_we;
                m_wdata  = d_wdata;
                m_starve = i_req ? ((m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT) : 0;
            end else if (i_req) begin
                m_owner  = PI;
                m_acc    = 1'b0;
                m_addr   = i_addr;
                m_we     = 1'b0;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end else begin
            if (!m_acc) begin
                if (mem_gnt) m_acc = 1'b1;
                else if ((m_owner == PI && !i_req) || (m_owner == PD && !d_req)) m_owner = NONE;
            end else if (mem_rvalid) begin
                m_owner = NONE;
            end
            if (!i_req) m_starve = 0;
        end
    endtask

    // Compare all DUT outputs against the model for the current cycle.
    task automatic compare_all();
        logic exp_req, exp_ir, exp_dr;
        exp_req = (m_owner != NONE) && !m_acc;
        exp_ir  = (m_owner == PI) && m_acc && mem_rvalid;
        exp_dr  = (m_owner == PD) && m_acc && mem_rvalid;
        check("mem_req", mem_req, exp_req);
        check("i_ready", i_ready, exp_ir);
        check("d_ready", d_ready, exp_dr);
        check("both_ready", i_ready & d_ready, 0);
        if (exp_req) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (exp_ir) check("i_rdata", i_rdata, mem_rdata);
        if (exp_dr) check("d_rdata", d_rdata, mem_rdata);
        obs_i = i_ready;
        obs_d = d_ready;
    endtask

    // Rising edge: advance the model, then give the caller a point to drive this cycle's inputs.
    task automatic tick_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int  dpc, ipc, dcnt, icnt, first_i, second_i, dly;
        bit  pulses[$];
        bit  pend, acc_prev;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        tick_edge(); reset = 1'b1; sample();

        // fetch only, gnt tied high, response in the first wait cycle
        tick_edge(); i_req = 1'b1; i_addr = 32'h40; mem_gnt = 1'b1; sample();
        tick_edge(); sample();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_mem_we", mem_we, 0);
        tick_edge(); mem_rvalid = 1'b1; mem_rdata = 32'h8C0A0004; sample();
        check("t1_i_ready_c2", i_ready, 1);
        check("t1_i_rdata", i_rdata, 32'h8C0A0004);
        tick_edge(); clear_inputs(); sample();
        check("t1_i_ready_c3", i_ready, 0);

        // store only, grant delayed three cycles
        tick_edge(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; sample();
        for (int c = 1; c <= 3; c++) begin
            tick_edge(); if (c == 3) mem_gnt = 1'b1; sample();
            check("t2_mem_req_held", mem_req, 1);
            check("t2_mem_addr", mem_addr, 32'h100);
            check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
            check("t2_mem_we", mem_we, 1);
        end
        tick_edge(); mem_gnt = 1'b0; mem_rvalid = 1'b1; sample();
        check("t2_mem_req_low", mem_req, 0);
        check("t2_d_ready", d_ready, 1);
        check("t2_no_i_ready", i_ready, 0);
        tick_edge(); clear_inputs(); sample();

        // conflict: both request at once, data single, fetch held
        dpc = -1; ipc = -1; dcnt = 0; icnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick_edge();
            if (c == 0) begin
                i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
                mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
            end else begin
                if (obs_d) d_req = 1'b0;
                if (obs_i) i_req = 1'b0;
            end
            sample();
            if (d_ready) begin dcnt++; if (dpc < 0) dpc = c; end
            if (i_ready) begin icnt++; if (ipc < 0) ipc = c; end
        end
        check("t3_d_cycle", dpc, 2);
        check("t3_i_cycle", ipc, 5);
        check("t3_d_count", dcnt, 1);
        check("t3_i_count", icnt, 1);
        tick_edge(); clear_inputs(); sample();

        // starvation: fetch held, data back-to-back
        for (int c = 0; c < 40; c++) begin
            tick_edge();
            if (c == 0) begin
                i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
                mem_gnt = 1'b1; mem_rvalid = 1'b1;
            end else begin
                if (obs_d) d_addr = d_addr + 32'd4;
                if (obs_i) i_addr = i_addr + 32'd4;
            end
            sample();
            if (d_ready) pulses.push_back(1'b0);
            if (i_ready) pulses.push_back(1'b1);
        end
        first_i = -1; second_i = -1;
        foreach (pulses[k]) begin
            if (pulses[k]) begin
                if (first_i < 0) first_i = k;
                else if (second_i < 0) second_i = k;
            end
        end
        check("t4_first_fetch_pos", first_i, 4);
        check("t4_gap_after_fetch", second_i - first_i - 1, 4);
        tick_edge(); clear_inputs(); sample();

        // flush: fetch dropped before grant, then a normal load
        tick_edge(); i_req = 1'b1; i_addr = 32'h300; sample();
        tick_edge(); sample();
        check("t5_mem_req_up", mem_req, 1);
        tick_edge(); i_req = 1'b0; sample();
        tick_edge(); sample();
        check("t5_mem_req_down", mem_req, 0);
        check("t5_no_i_ready", i_ready, 0);
        tick_edge(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_gnt = 1'b1; sample();
        tick_edge(); sample();
        check("t5_d_addr", mem_addr, 32'h400);
        tick_edge(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001; sample();
        check("t5_d_ready", d_ready, 1);
        check("t5_d_rdata", d_rdata, 32'hCAFE0001);
        tick_edge(); clear_inputs(); sample();

        // reset in WAIT_D, late response ignored, then a normal fetch
        tick_edge(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; mem_gnt = 1'b1; sample();
        tick_edge(); sample();
        tick_edge(); mem_gnt = 1'b0; sample();
        #1 reset = 1'b0;
        model_reset();
        #1;
        check("t6_rst_mem_req", mem_req, 0);
        check("t6_rst_mem_we", mem_we, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_mem_wdata", mem_wdata, 0);
        check("t6_rst_i_ready", i_ready, 0);
        check("t6_rst_d_ready", d_ready, 0);
        d_req = 1'b0;
        tick_edge(); reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD; sample();
        check("t6_late_rvalid", d_ready, 0);
        tick_edge(); mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h44; mem_gnt = 1'b1; sample();
        tick_edge(); sample();
        check("t6_fetch_addr", mem_addr, 32'h44);
        tick_edge(); mem_rvalid = 1'b1; mem_rdata = 32'h600D0001; sample();
        check("t6_fetch_ready", i_ready, 1);
        tick_edge(); clear_inputs(); sample();

        // randomized traffic with a responsive memory
        pend = 1'b0; acc_prev = 1'b0; dly = 0;
        for (int c = 0; c < 3000; c++) begin
            tick_edge();
            if (acc_prev) begin pend = 1'b1; dly = int'($urandom_range(0, 2)); end
            mem_rvalid = 1'b0;
            if (pend) begin
                if (dly == 0) begin mem_rvalid = 1'b1; pend = 1'b0; end
                else dly--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1;
            end
            mem_rdata = $urandom;
            mem_gnt   = 1'($urandom_range(0, 1));
            acc_prev  = mem_req && mem_gnt;
            if (i_req) begin
                if (obs_i || $urandom_range(0, 15) == 0) begin
                    i_req  = 1'($urandom_range(0, 1));
                    i_addr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = $urandom;
            end
            if (d_req) begin
                if (obs_d || $urandom_range(0, 15) == 0) begin
                    d_req   = 1'($urandom_range(0, 1));
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            sample();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
